// File: rtl/harmonic_scheduler.sv
// Frame controller for the additive-synthesis harmonic engine: sequences harmonics, weights and sums samples.
// Build option: define HARMONIC_SCHED_SATURATE_EN to clamp the output instead of wrapping it.
//
// state        | meaning
// S_IDLE       | waiting for an output-rate tick
// S_WAIT_READY | waiting for the engine to present the current harmonic
// S_CAPTURE    | second ready cycle, sine LUT output registered
// S_MAC        | weight sample by level, accumulate, decay level
// S_ADVANCE    | move engine to next harmonic or end the frame
// S_FINISH     | park engine back on harmonic 0
// S_OUTPUT     | narrow accumulator onto o_Sample
module harmonic_scheduler #(
  parameter logic [7:0] LEVEL_INIT = 8'd255,
  parameter int         ACC_W      = 32,
  parameter int         OUT_SHIFT  = 10
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Tick,
  input  logic [7:0]  i_Harmonic_Count,
  input  logic [7:0]  i_Decay,
  output logic [7:0]  o_Harmonic,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  input  logic        i_Freq_Too_High,
  output logic        o_Next_Sample,
  output logic [15:0] o_Sample,
  output logic        o_Sample_Valid,
  output logic        o_Busy,
  output logic        o_Overrun,
  output logic [7:0]  o_Harmonics_Used
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_CAPTURE, S_MAC, S_ADVANCE, S_FINISH, S_OUTPUT
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               count_q, count_d;
  logic [7:0]               decay_q, decay_d;
  logic [7:0]               level_q, level_d;
  logic [7:0]               used_q, used_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [15:0]       value_q, value_d;
  logic [7:0]               harmonic_q, harmonic_d;
  logic                     next_sample_q, next_sample_d;
  logic [15:0]              sample_q, sample_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic [7:0]               used_out_q, used_out_d;

  logic signed [24:0]       product;
  logic [15:0]              level_prod;
  logic [15:0]              sample_narrow;

  assign product    = 25'(value_q) * 25'($signed({1'b0, level_q}));
  assign level_prod = {8'd0, level_q} * {8'd0, decay_q};

`ifdef HARMONIC_SCHED_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
  logic signed [ACC_W-1:0] acc_shifted;
  assign acc_shifted = acc_q >>> OUT_SHIFT;

  always_comb begin
    if (acc_shifted > SAT_MAX)      sample_narrow = 16'h7fff;
    else if (acc_shifted < SAT_MIN) sample_narrow = 16'h8000;
    else                            sample_narrow = acc_shifted[15:0];
  end
`else
  assign sample_narrow = 16'(acc_q >>> OUT_SHIFT);
`endif

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    decay_d        = decay_q;
    level_d        = level_q;
    used_d         = used_q;
    acc_d          = acc_q;
    value_d        = value_q;
    harmonic_d     = harmonic_q;
    next_sample_d  = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    busy_d         = busy_q;
    used_out_d     = used_out_q;
    overrun_d      = i_Sample_Tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (i_Sample_Tick) begin
          count_d    = i_Harmonic_Count;
          decay_d    = i_Decay;
          acc_d      = '0;
          level_d    = LEVEL_INIT;
          used_d     = 8'd0;
          harmonic_d = 8'd0;
          if (i_Harmonic_Count == 8'd0) begin
            state_d = S_OUTPUT;
          end else begin
            busy_d  = 1'b1;
            state_d = S_WAIT_READY;
          end
        end
      end
      // Ready is still high while our release pulse is out; it belongs to the previous harmonic.
      S_WAIT_READY: if (i_Sample_Ready && !next_sample_q) state_d = S_CAPTURE;
      S_CAPTURE: begin
        value_d = $signed(i_Sample_Value);
        state_d = i_Freq_Too_High ? S_FINISH : S_MAC;
      end
      S_MAC: begin
        acc_d   = acc_q + ACC_W'(product);
        level_d = 8'(level_prod >> 8);
        used_d  = used_q + 8'd1;
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (used_q == count_q) begin
          state_d = S_FINISH;
        end else begin
          harmonic_d    = harmonic_q + 8'd1;
          next_sample_d = 1'b1;
          state_d       = S_WAIT_READY;
        end
      end
      S_FINISH: begin
        harmonic_d    = 8'd0;
        next_sample_d = 1'b1;
        state_d       = S_OUTPUT;
      end
      S_OUTPUT: begin
        sample_d       = sample_narrow;
        used_out_d     = used_q;
        sample_valid_d = 1'b1;
        busy_d         = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q        <= S_IDLE;
      count_q        <= 8'd0;
      decay_q        <= 8'd0;
      level_q        <= LEVEL_INIT;
      used_q         <= 8'd0;
      acc_q          <= '0;
      value_q        <= '0;
      harmonic_q     <= 8'd0;
      next_sample_q  <= 1'b0;
      sample_q       <= 16'd0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      used_out_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      decay_q        <= decay_d;
      level_q        <= level_d;
      used_q         <= used_d;
      acc_q          <= acc_d;
      value_q        <= value_d;
      harmonic_q     <= harmonic_d;
      next_sample_q  <= next_sample_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      used_out_q     <= used_out_d;
    end
  end

  assign o_Harmonic       = harmonic_q;
  assign o_Next_Sample    = next_sample_q;
  assign o_Sample         = sample_q;
  assign o_Sample_Valid   = sample_valid_q;
  assign o_Busy           = busy_q;
  assign o_Overrun        = overrun_q;
  assign o_Harmonics_Used = used_out_q;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Bench for harmonic_scheduler: engine model on the falling edge, frame-level arithmetic reference.
module tb_harmonic_scheduler;

  localparam int LEVEL_INIT = 255;
  localparam int OUT_SHIFT  = 10;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Sample_Tick = 1'b0;
  logic [7:0]  i_Harmonic_Count = 8'd0;
  logic [7:0]  i_Decay = 8'd0;
  logic [7:0]  o_Harmonic;
  logic        i_Sample_Ready = 1'b0;
  logic [15:0] i_Sample_Value = 16'd0;
  logic        i_Freq_Too_High = 1'b0;
  logic        o_Next_Sample;
  logic [15:0] o_Sample;
  logic        o_Sample_Valid;
  logic        o_Busy;
  logic        o_Overrun;
  logic [7:0]  o_Harmonics_Used;

  always #5 i_Clock = ~i_Clock;

  harmonic_scheduler dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_Sample_Tick    (i_Sample_Tick),
    .i_Harmonic_Count (i_Harmonic_Count),
    .i_Decay          (i_Decay),
    .o_Harmonic       (o_Harmonic),
    .i_Sample_Ready   (i_Sample_Ready),
    .i_Sample_Value   (i_Sample_Value),
    .i_Freq_Too_High  (i_Freq_Too_High),
    .o_Next_Sample    (o_Next_Sample),
    .o_Sample         (o_Sample),
    .o_Sample_Valid   (o_Sample_Valid),
    .o_Busy           (o_Busy),
    .o_Overrun        (o_Overrun),
    .o_Harmonics_Used (o_Harmonics_Used)
  );

  logic signed [15:0] vals [256];
  int          limit_idx = 1000;
  logic [7:0]  pulse_q [$];
  int          valid_cnt = 0, overrun_cnt = 0, ready_viol = 0, eng_wait = 0;
  logic [15:0] last_sample = 16'd0;
  logic [7:0]  last_used = 8'd0;
  int          n_checks = 0, n_pass = 0, n_fail = 0;

  // Monitor first, then the engine reacts to what it saw this cycle.
  always @(negedge i_Clock) begin
    if (o_Next_Sample) begin
      pulse_q.push_back(o_Harmonic);
      if (!i_Sample_Ready) ready_viol++;
    end
    if (o_Sample_Valid) begin
      valid_cnt++;
      last_sample = o_Sample;
      last_used   = o_Harmonics_Used;
    end
    if (o_Overrun) overrun_cnt++;
    if (i_Reset || o_Next_Sample) begin
      i_Sample_Ready = 1'b0;
      eng_wait = int'($urandom_range(0, 3));
    end else if (!i_Sample_Ready) begin
      if (eng_wait == 0) i_Sample_Ready = 1'b1;
      else eng_wait--;
    end
    i_Sample_Value  = vals[o_Harmonic];
    i_Freq_Too_High = (int'(o_Harmonic) >= limit_idx);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int cnt, input int dec, input int lim,
                                output logic [15:0] samp, output int used, output int npulse);
    longint acc = 0;
    int level = LEVEL_INIT;
    logic signed [31:0] a32, sh;
    used = 0;
    for (int h = 0; h < cnt; h++) begin
      if (h >= lim) break;
      acc += longint'(vals[h]) * longint'(level);
      level = level * dec / 256;
      used++;
    end
    a32 = acc[31:0];
    sh  = a32 >>> OUT_SHIFT;
`ifdef HARMONIC_SCHED_SATURATE_EN
    if (sh > 32767)       samp = 16'h7fff;
    else if (sh < -32768) samp = 16'h8000;
    else                  samp = sh[15:0];
`else
    samp = sh[15:0];
`endif
    if (cnt == 0)       npulse = 0;
    else if (used < cnt) npulse = used + 1;
    else                npulse = cnt;
  endfunction

  task automatic run_frame(input int cnt, input int dec, input int lim, input int second_tick, input string tag);
    int v0, o0, r0, p0, used, np;
    logic [15:0] samp;
    limit_idx = lim;
    i_Harmonic_Count = 8'(cnt);
    i_Decay = 8'(dec);
    v0 = valid_cnt; o0 = overrun_cnt; r0 = ready_viol; p0 = pulse_q.size();
    model(cnt, dec, lim, samp, used, np);
    @(posedge i_Clock); #1;
    i_Sample_Tick = 1'b1;
    @(posedge i_Clock); #1;
    i_Sample_Tick = 1'b0;
    i_Harmonic_Count = 8'($urandom);
    i_Decay = 8'($urandom);
    if (cnt != 0) check({tag, " busy"}, 32'(o_Busy), 32'd1);
    if (second_tick > 0) begin
      repeat (second_tick - 1) begin @(posedge i_Clock); #1; end
      i_Sample_Tick = 1'b1;
      @(posedge i_Clock); #1;
      i_Sample_Tick = 1'b0;
    end
    for (int k = 0; k < 6000; k++) begin
      if (valid_cnt != v0) break;
      @(posedge i_Clock); #1;
    end
    repeat (3) begin @(posedge i_Clock); #1; end
    check({tag, " valid count"}, 32'(valid_cnt - v0), 32'd1);
    check({tag, " sample"}, 32'(last_sample), 32'(samp));
    check({tag, " used"}, 32'(last_used), 32'(used));
    check({tag, " pulses"}, 32'(pulse_q.size() - p0), 32'(np));
    for (int i = 0; i < np && p0 + i < pulse_q.size(); i++)
      check({tag, " pulse harmonic"}, 32'(pulse_q[p0 + i]), (i == np - 1) ? 32'd0 : 32'(i + 1));
    check({tag, " ready at pulse"}, 32'(ready_viol - r0), 32'd0);
    check({tag, " overrun"}, 32'(overrun_cnt - o0), (second_tick > 0) ? 32'd1 : 32'd0);
    check({tag, " busy after"}, 32'(o_Busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " harmonic"}, 32'(o_Harmonic), 32'd0);
    check({tag, " next"}, 32'(o_Next_Sample), 32'd0);
    check({tag, " sample"}, 32'(o_Sample), 32'd0);
    check({tag, " valid"}, 32'(o_Sample_Valid), 32'd0);
    check({tag, " busy"}, 32'(o_Busy), 32'd0);
    check({tag, " overrun"}, 32'(o_Overrun), 32'd0);
    check({tag, " used"}, 32'(o_Harmonics_Used), 32'd0);
  endtask

  initial begin
    int v0, p0, cnt, dec, lim;
    for (int h = 0; h < 256; h++) vals[h] = 16'sd0;
    repeat (3) @(posedge i_Clock);
    #1;
    check_reset_outputs("reset");
    i_Reset = 1'b0;
    repeat (6) begin @(posedge i_Clock); #1; end

    for (int h = 0; h < 256; h++) vals[h] = 16'sd1000;
    run_frame(1, 0, 1000, 0, "single");
    check("single literal", 32'(last_sample), 32'd249);
    run_frame(3, 128, 1000, 0, "three");
    check("three literal", 32'(last_sample), 32'd434);

    for (int h = 0; h < 256; h++) vals[h] = 16'(500 + 100 * h);
    run_frame(8, 200, 3, 0, "flimit");
    check("flimit used literal", 32'(last_used), 32'd3);
    run_frame(4, 100, 1000, 3, "overrun");
    run_frame(5, 90, 0, 0, "limit at 0");

    for (int h = 0; h < 256; h++) vals[h] = 16'sd32767;
    run_frame(2, 255, 1000, 0, "sat2");
    run_frame(8, 255, 1000, 0, "sat8");
    for (int h = 0; h < 256; h++) vals[h] = -16'sd32768;
    run_frame(7, 250, 1000, 0, "negsat");

    // zero-harmonic frame: result two cycles after the tick, no engine traffic
    p0 = pulse_q.size();
    i_Harmonic_Count = 8'd0;
    @(posedge i_Clock); #1;
    i_Sample_Tick = 1'b1;
    @(posedge i_Clock); #1;
    i_Sample_Tick = 1'b0;
    check("count0 early valid", 32'(o_Sample_Valid), 32'd0);
    @(posedge i_Clock); #1;
    check("count0 valid", 32'(o_Sample_Valid), 32'd1);
    check("count0 sample", 32'(o_Sample), 32'd0);
    check("count0 used", 32'(o_Harmonics_Used), 32'd0);
    repeat (4) begin @(posedge i_Clock); #1; end
    check("count0 pulses", 32'(pulse_q.size() - p0), 32'd0);

    for (int f = 0; f < 6; f++) begin
      for (int h = 0; h < 256; h++) vals[h] = 16'($urandom);
      cnt = int'($urandom_range(0, 12));
      dec = int'($urandom_range(0, 255));
      lim = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : 1000;
      run_frame(cnt, dec, lim, 0, "random");
    end

    for (int h = 0; h < 256; h++) vals[h] = 16'sd32767;
    run_frame(255, 255, 1000, 0, "count255");

    // reset partway through a frame
    for (int h = 0; h < 256; h++) vals[h] = 16'sd1000;
    limit_idx = 1000;
    i_Harmonic_Count = 8'd6;
    i_Decay = 8'd128;
    v0 = valid_cnt;
    @(posedge i_Clock); #1;
    i_Sample_Tick = 1'b1;
    @(posedge i_Clock); #1;
    i_Sample_Tick = 1'b0;
    repeat (8) begin @(posedge i_Clock); #1; end
    i_Reset = 1'b1;
    @(posedge i_Clock); #1;
    check_reset_outputs("midreset");
    i_Reset = 1'b0;
    repeat (40) begin @(posedge i_Clock); #1; end
    check("midreset no valid", 32'(valid_cnt - v0), 32'd0);
    run_frame(3, 128, 1000, 0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/harmonic_scheduler.md
Name: harmonic_scheduler

Overview:
- Frame controller for the additive-synthesis harmonic engine (the sample position / sine LUT stage).
- On each output-rate tick, it walks the engine through harmonics 0..N-1 and handshakes each sample.
- Each sample is weighted by a geometrically decaying level and summed; summing stops early when the engine flags a frequency that is too high.
- Emits one 16-bit signed mixed sample per tick toward the DAC path.

Parameters:
- LEVEL_INIT, 8'd255, amplitude level applied to harmonic 0.
- ACC_W, 32, accumulator width in bits; signed.
- OUT_SHIFT, 10, arithmetic right shift applied to the accumulator before the output is narrowed.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Sample_Tick  in  1  one-cycle pulse per output sample period.
- i_Harmonic_Count  in  8  number of harmonics to sum; latched at frame start.
- i_Decay  in  8  per-harmonic level multiplier, applied as level*decay/256; latched at frame start.
- o_Harmonic  out  8  harmonic index presented to the engine.
- i_Sample_Ready  in  1  engine: sample for o_Harmonic is being produced.
- i_Sample_Value  in  16  engine sine output, signed two's complement.
- i_Freq_Too_High  in  1  engine: accumulated frequency for this harmonic exceeds 20000.
- o_Next_Sample  out  1  one-cycle pulse that releases the engine to the next harmonic.
- o_Sample  out  16  mixed output, signed.
- o_Sample_Valid  out  1  one-cycle pulse when o_Sample updates.
- o_Busy  out  1  frame in progress.
- o_Overrun  out  1  one-cycle pulse: tick arrived while busy.
- o_Harmonics_Used  out  8  harmonics summed in the last frame.

Behaviour:
- Reset values:
  - o_Harmonic = 0, o_Next_Sample = 0, o_Sample = 0, o_Sample_Valid = 0, o_Busy = 0, o_Overrun = 0, o_Harmonics_Used = 0.
  - Accumulator = 0, level = LEVEL_INIT, state = IDLE.
  - The engine shares i_Reset; a reset mid-frame abandons the frame and produces no output.
- State IDLE:
  - On i_Sample_Tick: latch count and decay, clear the accumulator, level <= LEVEL_INIT, o_Harmonic <= 0.
  - If count == 0: go to OUTPUT. Otherwise set o_Busy = 1 and go to WAIT_READY.
- State WAIT_READY: wait for i_Sample_Ready = 1, then go to CAPTURE.
- State CAPTURE:
  - Occupies the second consecutive cycle of i_Sample_Ready high; the sine LUT output is registered one cycle after ready rises.
  - Register i_Sample_Value and i_Freq_Too_High.
  - If i_Freq_Too_High = 1, go to FINISH without accumulating. Otherwise go to MAC.
- State MAC:
  - acc <= acc + sign_extend(value * {1'b0, level}); the product is 25-bit signed.
  - level <= (level * decay) >> 8.
  - used <= used + 1.
  - Go to ADVANCE.
- State ADVANCE:
  - If used == count, go to FINISH.
  - Otherwise o_Harmonic <= o_Harmonic + 1, pulse o_Next_Sample for one cycle, and go to WAIT_READY.
  - o_Harmonic changes in the same cycle as the pulse and holds until the next pulse.
- State FINISH:
  - o_Harmonic <= 0 and pulse o_Next_Sample. This re-initialises the engine, which then parks on harmonic 0 awaiting the next frame.
  - Go to OUTPUT.
- State OUTPUT:
  - o_Sample <= narrow(acc >>> OUT_SHIFT), o_Harmonics_Used <= used.
  - Pulse o_Sample_Valid; o_Busy <= 0; go to IDLE.
  - Output latency from tick is 1 + 4 cycles per harmonic + engine wait + 2 cycles.
- Tick handling outside IDLE:
  - i_Sample_Tick in any non-IDLE state is dropped and o_Overrun pulses in the following cycle.
  - Ticks are never queued.
- Inputs: i_Harmonic_Count and i_Decay changes mid-frame are ignored.
- Level decay: reaching 0 does not end the frame; contributions become 0 but harmonics are still sequenced.
- i_Harmonic_Count = 255: o_Harmonic reaches 254 as the last index, and the wrap to 0 occurs only through FINISH.
- o_Next_Sample never pulses while the engine's i_Sample_Ready is low.

Optional Feature:
- Macro: HARMONIC_SCHED_SATURATE_EN.
- Defined: narrow clamps acc >>> OUT_SHIFT to the range [-32768, 32767].
- Undefined: narrow takes bits [15:0] of acc >>> OUT_SHIFT, wrapping two's complement.

Test Plan:
- Single harmonic:
  - Stimulus: count = 1, decay = 0, engine model returns value 16'd1000.
  - Response: o_Sample = (1000*255) >>> 10 = 249; o_Harmonics_Used = 1; exactly 1 o_Next_Sample pulse, with o_Harmonic = 0 at that pulse.
- Three harmonics:
  - Stimulus: count = 3, decay = 128, values 1000, 1000, 1000.
  - Response: levels 255, 127, 63; o_Sample = (1000*445) >>> 10 = 434; o_Harmonic sequence 1, 2, 0 on the pulses.
- Frequency limit:
  - Stimulus: count = 8, model raises i_Freq_Too_High at harmonic 3.
  - Response: o_Harmonics_Used = 3; FINISH pulse with o_Harmonic = 0; no accumulation of harmonic 3.
- Overrun:
  - Stimulus: tick, then a second tick 3 cycles later while busy.
  - Response: o_Overrun pulses once; exactly one o_Sample_Valid for the frame.
- Saturation:
  - Stimulus: OUT_SHIFT = 0, count = 2, decay = 255, values 32767, 32767.
  - Response with macro defined: o_Sample = 32767. Without the macro: o_Sample = low 16 bits of the sum.
- Edge cases:
  - count = 0: o_Sample = 0 two cycles after the tick, with no o_Next_Sample pulse.
  - Reset mid-frame: all outputs return to reset values the next cycle, and no o_Sample_Valid is produced.
